// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road signal sequencer with optional pedestrian walk phase and night flash mode.
// Latency: lamps and phase are decoded from registered state; the first change appears one clk after the deciding edge.
// Backpressure: none; inputs are sampled every cycle, and a pedestrian request is held pending until WALK is entered.
// Build option: define TRAFFIC_PED_REQ_EN to make WALK conditional on a pending request.
// Without it, ped_req is ignored and WALK follows every R2Y.
module traffic_ctrl #(
  parameter int unsigned G_CYC = 10,
  parameter int unsigned Y_CYC = 3,
  parameter int unsigned W_CYC = 5,
  parameter int unsigned F_CYC = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       night,
  input  logic       ped_req,
  output logic       Road1_G,
  output logic       Road1_Y,
  output logic       Road1_R,
  output logic       Road2_G,
  output logic       Road2_Y,
  output logic       Road2_R,
  output logic       Walk_G,
  output logic       Walk_R,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_R1G   = 3'd0,
    S_R1Y   = 3'd1,
    S_R2G   = 3'd2,
    S_R2Y   = 3'd3,
    S_WALK  = 3'd4,
    S_FLASH = 3'd5
  } state_t;

  // Last counter value of each phase.
  // In FLASH, the counter measures one blink half-period instead.
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_CYC - 1);
  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(F_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_cnt;
  logic               phase_end;
  logic               blink_q, blink_d;
  logic               walk_due;

`ifdef TRAFFIC_PED_REQ_EN
  logic ped_pend_q, ped_pend_d;

  assign walk_due = ped_pend_q;

  // A request latches outside WALK.
  // Entering WALK serves it, and that clear wins over a same-cycle request.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == S_WALK && state_q != S_WALK) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && state_q != S_WALK) begin
      ped_pend_d = 1'b1;
    end
  end

  // Pending-request register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
    end
  end
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign walk_due       = 1'b1;
`endif

  // Select the terminal count of the current phase.
  always_comb begin
    last_cnt = G_LAST;
    case (state_q)
      S_R1G, S_R2G: last_cnt = G_LAST;
      S_R1Y, S_R2Y: last_cnt = Y_LAST;
      S_WALK:       last_cnt = W_LAST;
      S_FLASH:      last_cnt = F_LAST;
      default:      last_cnt = G_LAST;
    endcase
  end

  assign phase_end = (cnt_q == last_cnt);

  // Next state, phase counter and blink.
  // Night mode is honoured only at the end of a yellow or walk phase, so a green is never cut short.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    blink_d = 1'b0;
    case (state_q)
      S_R1G: begin
        if (phase_end) state_d = S_R1Y;
      end
      S_R1Y: begin
        if (phase_end) state_d = night ? S_FLASH : S_R2G;
      end
      S_R2G: begin
        if (phase_end) state_d = S_R2Y;
      end
      S_R2Y: begin
        if (phase_end) begin
          if (night)         state_d = S_FLASH;
          else if (walk_due) state_d = S_WALK;
          else               state_d = S_R1G;
        end
      end
      S_WALK: begin
        if (phase_end) state_d = night ? S_FLASH : S_R1G;
      end
      S_FLASH: begin
        if (!night) begin
          state_d = S_R1G;
          cnt_d   = '0;
        end else if (phase_end) begin
          cnt_d   = '0;
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
      end
      default: begin
        state_d = S_R1G;
        cnt_d   = '0;
      end
    endcase
    if (state_q != S_FLASH && phase_end) begin
      cnt_d = '0;
    end
    if (state_q != S_FLASH && state_d == S_FLASH) begin
      blink_d = 1'b1;
    end
  end

  // State register; reset returns to the start of road 1 green from any phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_R1G;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  // Moore lamp decode.
  // Outside FLASH, exactly one lamp per road and one walk lamp is lit.
  always_comb begin
    Road1_G = 1'b0;
    Road1_Y = 1'b0;
    Road1_R = 1'b0;
    Road2_G = 1'b0;
    Road2_Y = 1'b0;
    Road2_R = 1'b0;
    Walk_G  = 1'b0;
    Walk_R  = 1'b1;
    case (state_q)
      S_R1G: begin
        Road1_G = 1'b1;
        Road2_R = 1'b1;
      end
      S_R1Y: begin
        Road1_Y = 1'b1;
        Road2_R = 1'b1;
      end
      S_R2G: begin
        Road1_R = 1'b1;
        Road2_G = 1'b1;
      end
      S_R2Y: begin
        Road1_R = 1'b1;
        Road2_Y = 1'b1;
      end
      S_WALK: begin
        Road1_R = 1'b1;
        Road2_R = 1'b1;
        Walk_G  = 1'b1;
        Walk_R  = 1'b0;
      end
      S_FLASH: begin
        Road1_Y = blink_q;
        Road2_Y = blink_q;
      end
      default: begin
        Road1_R = 1'b1;
        Road2_R = 1'b1;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: directed scenarios plus randomized traffic, checked against a phase/time-left model.
// Each task drives inputs one cycle at a time and compares every lamp and the phase after each edge.
module tb_traffic_ctrl;

  localparam int G_CYC = 10;
  localparam int Y_CYC = 3;
  localparam int W_CYC = 5;
  localparam int F_CYC = 2;

`ifdef TRAFFIC_PED_REQ_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic night;
  logic ped_req;
  logic Road1_G, Road1_Y, Road1_R;
  logic Road2_G, Road2_Y, Road2_R;
  logic Walk_G, Walk_R;
  logic [2:0] phase;

  int n_vec;
  int n_err;

  // Model state: current phase, cycles left in it, pending walk request, cycles spent in FLASH.
  int m_phase;
  int m_left;
  bit m_pend;
  int m_age;

  traffic_ctrl #(
    .G_CYC(G_CYC), .Y_CYC(Y_CYC), .W_CYC(W_CYC), .F_CYC(F_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .night(night), .ped_req(ped_req),
    .Road1_G(Road1_G), .Road1_Y(Road1_Y), .Road1_R(Road1_R),
    .Road2_G(Road2_G), .Road2_Y(Road2_Y), .Road2_R(Road2_R),
    .Walk_G(Walk_G), .Walk_R(Walk_R), .phase(phase)
  );

  wire logic [10:0] dut_out = {phase, Road1_G, Road1_Y, Road1_R,
                               Road2_G, Road2_Y, Road2_R, Walk_G, Walk_R};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      0, 2:    return G_CYC;
      1, 3:    return Y_CYC;
      default: return W_CYC;
    endcase
  endfunction

  // Expected {phase, lamps} for the model's current phase.
  // Flash brightness is a function of time spent in FLASH.
  function automatic logic [10:0] exp_out();
    logic b;
    b = ((m_age / F_CYC) % 2) == 0;
    case (m_phase)
      0:       return {3'd0, 8'b1000_0101};
      1:       return {3'd1, 8'b0100_0101};
      2:       return {3'd2, 8'b0011_0001};
      3:       return {3'd3, 8'b0010_1001};
      4:       return {3'd4, 8'b0010_0110};
      default: return {3'd5, 1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  // Phase expected t cycles after reset with no night or requests: a fixed repeating schedule.
  function automatic logic [2:0] sched_phase(input int t);
    int per;
    int u;
    per = 2 * G_CYC + 2 * Y_CYC + (PED_EN ? 0 : W_CYC);
    u   = t % per;
    if (u < G_CYC)                  return 3'd0;
    if (u < G_CYC + Y_CYC)          return 3'd1;
    if (u < 2 * G_CYC + Y_CYC)      return 3'd2;
    if (u < 2 * G_CYC + 2 * Y_CYC)  return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_step(input logic r, input logic n, input logic p);
    int nxt;
    bit set_p;
    if (r) begin
      m_phase = 0; m_left = G_CYC; m_pend = 1'b0; m_age = 0;
      return;
    end
    set_p = PED_EN && p && (m_phase != 4);
    if (m_phase == 5) begin
      if (!n) begin
        m_phase = 0; m_left = G_CYC; m_age = 0;
      end else begin
        m_age++;
      end
      m_pend = m_pend | set_p;
      return;
    end
    if (m_left > 1) begin
      m_left--;
      m_pend = m_pend | set_p;
      return;
    end
    case (m_phase)
      0:       nxt = 1;
      1:       nxt = n ? 5 : 2;
      2:       nxt = 3;
      3:       nxt = n ? 5 : ((m_pend || !PED_EN) ? 4 : 0);
      default: nxt = n ? 5 : 0;
    endcase
    m_pend  = (nxt == 4) ? 1'b0 : (m_pend | set_p);
    m_phase = nxt;
    m_left  = dur(nxt);
    m_age   = 0;
  endtask

  // Apply inputs for one edge, advance the model, and leave time 1 unit past the edge for sampling.
  task automatic tick(input logic r, input logic n, input logic p);
    rst = r; night = n; ped_req = p;
    @(posedge clk);
    model_step(r, n, p);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (dut_out !== exp_out()) begin
      n_err++; $display("FAIL reset_out got=%h exp=%h", dut_out, exp_out());
    end
    n_vec++;
    if ({phase, Road1_G, Road2_R, Walk_R, Walk_G} !== {3'd0, 4'b1110}) begin
      n_err++; $display("FAIL reset_lamps got=%b exp=%b",
                        {phase, Road1_G, Road2_R, Walk_R, Walk_G}, {3'd0, 4'b1110});
    end
  endtask

  task automatic test_normal();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 100; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL normal_model cyc=%0d got=%h exp=%h", i, dut_out, exp_out());
      end
      n_vec++;
      if (phase !== sched_phase(i)) begin
        n_err++; $display("FAIL normal_sched cyc=%0d got=%0d exp=%0d", i, phase, sched_phase(i));
      end
    end
  endtask

  task automatic test_ped();
    logic [2:0] want;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 70; i++) begin
      tick(1'b0, 1'b0, (i == 6));
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL ped_model cyc=%0d got=%h exp=%h", i, dut_out, exp_out());
      end
      if (i == 25 || i == 26 || i == 30 || i == 31 || i == 56 || i == 57) begin
        case (i)
          25:      want = 3'd3;
          26, 30:  want = 3'd4;
          31:      want = 3'd0;
          56:      want = 3'd3;
          default: want = PED_EN ? 3'd0 : 3'd4;
        endcase
        n_vec++;
        if (phase !== want) begin
          n_err++; $display("FAIL ped_phase cyc=%0d got=%0d exp=%0d", i, phase, want);
        end
      end
    end
  endtask

  task automatic test_night();
    logic exp_b;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 32; i++) begin
      tick(1'b0, (i >= 4 && i <= 18), 1'b0);
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL night_model cyc=%0d got=%h exp=%h", i, dut_out, exp_out());
      end
      if (i >= 13 && i <= 18) begin
        exp_b = (((i - 13) / 2) % 2) == 0;
        n_vec++;
        if ({phase, Road1_Y, Road2_Y} !== {3'd5, exp_b, exp_b}) begin
          n_err++; $display("FAIL night_blink cyc=%0d got=%b exp=%b",
                            i, {phase, Road1_Y, Road2_Y}, {3'd5, exp_b, exp_b});
        end
      end
      if (i == 12 || i == 19) begin
        n_vec++;
        if (phase !== ((i == 12) ? 3'd1 : 3'd0)) begin
          n_err++; $display("FAIL night_edge cyc=%0d got=%0d exp=%0d", i, phase, (i == 12) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_night_ped();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 90; i++) begin
      tick(1'b0, (i >= 20 && i <= 35), (i == 3));
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL nped_model cyc=%0d got=%h exp=%h", i, dut_out, exp_out());
      end
      if (i == 26 || i == 36 || i == 62) begin
        n_vec++;
        if (phase !== ((i == 26) ? 3'd5 : (i == 36) ? 3'd0 : 3'd4)) begin
          n_err++; $display("FAIL nped_phase cyc=%0d got=%0d", i, phase);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int green;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) tick(1'b0, 1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 resets mid-R2G; pass 1 holds night until FLASH and resets while flashing
      if (pass == 1) begin
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (phase !== 3'd5) begin
          n_err++; $display("FAIL rstmid_flash got=%0d exp=5", phase);
        end
      end
      tick(1'b1, pass[0], 1'b0);
      green = 1;
      while (phase === 3'd0 && green < 40) begin
        n_vec++;
        if (dut_out !== exp_out()) begin
          n_err++; $display("FAIL rstmid_model pass=%0d got=%h exp=%h", pass, dut_out, exp_out());
        end
        tick(1'b0, pass[0], 1'b0);
        if (phase === 3'd0) green++;
      end
      n_vec++;
      if (green !== G_CYC || phase !== 3'd1) begin
        n_err++; $display("FAIL rstmid_green pass=%0d got=%0d/%0d exp=%0d/1", pass, green, phase, G_CYC);
      end
    end
  endtask

  task automatic test_random();
    logic n;
    n = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) n = ~n;
      tick(($urandom_range(0, 149) == 0), n, ($urandom_range(0, 9) == 0));
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL random_model step=%0d got=%h exp=%h", i, dut_out, exp_out());
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; night = 1'b0; ped_req = 1'b0;
    m_phase = 0; m_left = G_CYC; m_pend = 1'b0; m_age = 0;
    test_reset();
    test_normal();
    test_ped();
    test_night();
    test_night_ped();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
